// File: rtl/csi2_pkg.sv
// Shared definitions for the CSI-2 lane transmitter: data types, lane FSM states,
// header ECC and serial CRC-16 helpers.
package csi2_pkg;

   localparam logic [5:0] DT_FS   = 6'h00;
   localparam logic [5:0] DT_FE   = 6'h01;
   localparam logic [5:0] DT_LS   = 6'h02;
   localparam logic [5:0] DT_LE   = 6'h03;
   localparam logic [5:0] DT_RAW8 = 6'h2A;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   typedef enum logic [3:0] {
      IDLE,
      LPX,
      PREP,
      HS_ZERO,
      SYNC,
      HEADER,
      PAYLOAD,
      CRC,
      TRAIL
   } tx_state_e;

   // d[7:0] is the data identifier, d[23:8] the word count.
   function automatic logic [7:0] csi2_ecc(input logic [23:0] d);
      logic [7:0] p;
      p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13]
           ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14]
           ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15]
           ^ d[18] ^ d[20] ^ d[21] ^ d[22];
      p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15]
           ^ d[19] ^ d[20] ^ d[21] ^ d[23];
      p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18]
           ^ d[19] ^ d[20] ^ d[22] ^ d[23];
      p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17]
           ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
      p[7:6] = 2'b00;
      return p;
   endfunction

   // Reflected x^16+x^12+x^5+1, one payload bit at a time.
   function automatic logic [15:0] csi2_crc16_bit(input logic [15:0] crc, input logic b);
      logic [15:0] nxt;
      nxt = {1'b0, crc[15:1]};
      if (crc[0] ^ b) nxt = nxt ^ 16'h8408;
      return nxt;
   endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Serial CRC-16 register; clear loads the 0xFFFF seed, enable folds in one bit.
module csi2_crc16 import csi2_pkg::*; (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic        bit_in,
   output logic [15:0] crc
);

   always_ff @(posedge clk) begin
      if (reset) crc <= '0;
      else if (clear) crc <= 16'hFFFF;
      else if (enable) crc <= csi2_crc16_bit(crc, bit_in);
   end

endmodule

// File: rtl/csi2_lane_tx.sv
// Single-lane CSI-2 transmitter: LP entry, bit-serial SYNC/header/payload/CRC, HS trail,
// plus the HS clock lane.
module csi2_lane_tx import csi2_pkg::*; #(
   parameter int T_LPX   = 2,
   parameter int T_PREP  = 2,
   parameter int T_ZERO  = 8,
   parameter int T_TRAIL = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pkt_valid,
   output logic        pkt_ready,
   input  logic [1:0]  pkt_vc,
   input  logic [5:0]  pkt_dt,
   input  logic [15:0] pkt_wc,
   input  logic [7:0]  pl_data,
   input  logic        pl_valid,
   output logic        pl_ready,
   output logic        data_p,
   output logic        data_n,
   output logic        clk_p,
   output logic        clk_n,
   output logic        busy,
   output logic        underrun
);

   tx_state_e   state, state_next;
   logic [5:0]  cnt;
   logic [2:0]  bit_cnt;
   logic [15:0] byte_cnt;
   logic [7:0]  pl_byte;
   logic [1:0]  hdr_vc;
   logic [5:0]  hdr_dt;
   logic [15:0] hdr_wc;
   logic        last_bit;
   logic        clk_tgl;
   logic [15:0] crc;
   logic [23:0] hdr;
   logic [31:0] hdr_word;
   logic        is_short;
   logic        last_byte;
   logic        hs_win;
   logic        tx_bit;
   logic        fetch;

   assign hdr       = {hdr_wc, hdr_vc, hdr_dt};
   assign hdr_word  = {csi2_ecc(hdr), hdr};
   assign is_short  = hdr_dt < 6'h10;
   assign last_byte = byte_cnt == hdr_wc - 16'd1;

   assign pkt_ready = (state == IDLE) && !reset;
   assign pl_ready  = fetch && !reset;
   assign underrun  = pl_ready && !pl_valid;
   assign busy      = state != IDLE;
   assign clk_p     = hs_win && !clk_tgl;
   assign clk_n     = !clk_p;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_next;
   end

   // cnt times every fixed-length phase; bit_cnt/byte_cnt only walk the payload.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         pl_byte  <= '0;
         hdr_vc   <= '0;
         hdr_dt   <= '0;
         hdr_wc   <= '0;
         last_bit <= 1'b0;
         clk_tgl  <= 1'b0;
      end else begin
         cnt     <= (state_next != state) ? 6'd0 : cnt + 6'd1;
         bit_cnt <= (state == PAYLOAD) ? bit_cnt + 3'd1 : 3'd0;
         if (state != PAYLOAD) byte_cnt <= '0;
         else if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 16'd1;
         if (state == IDLE && pkt_valid) begin
            hdr_vc <= pkt_vc;
            hdr_dt <= pkt_dt;
            hdr_wc <= pkt_wc;
         end
         if (fetch) pl_byte <= pl_valid ? pl_data : 8'h00;
         if (state inside {SYNC, HEADER, PAYLOAD, CRC}) last_bit <= tx_bit;
         clk_tgl <= hs_win ? !clk_tgl : 1'b0;
      end
   end

   always_comb begin
      state_next = state;
      tx_bit     = 1'b0;
      hs_win     = 1'b0;
      fetch      = 1'b0;
      data_p     = 1'b1;
      data_n     = 1'b1;
      case (state)
         IDLE: if (pkt_valid) state_next = LPX;
         LPX: begin
            data_p = 1'b0;
            if (cnt == 6'(T_LPX - 1)) state_next = PREP;
         end
         PREP: begin
            data_p = 1'b0;
            data_n = 1'b0;
            if (cnt == 6'(T_PREP - 1)) state_next = HS_ZERO;
         end
         HS_ZERO: begin
            hs_win = 1'b1;
            if (cnt == 6'(T_ZERO - 1)) state_next = SYNC;
         end
         SYNC: begin
            hs_win = 1'b1;
            tx_bit = SYNC_BYTE[cnt[2:0]];
            if (cnt == 6'd7) state_next = HEADER;
         end
         HEADER: begin
            hs_win = 1'b1;
            tx_bit = hdr_word[cnt[4:0]];
            if (cnt == 6'd31) begin
               if (is_short) state_next = TRAIL;
               else if (hdr_wc == 16'd0) state_next = CRC;
               else begin
                  state_next = PAYLOAD;
                  fetch      = 1'b1;
               end
            end
         end
         PAYLOAD: begin
            hs_win = 1'b1;
            tx_bit = pl_byte[bit_cnt];
            if (bit_cnt == 3'd7) begin
               if (last_byte) state_next = CRC;
               else fetch = 1'b1;
            end
         end
         CRC: begin
            hs_win = 1'b1;
            tx_bit = crc[cnt[3:0]];
            if (cnt == 6'd15) state_next = TRAIL;
         end
         TRAIL: begin
            hs_win = 1'b1;
            tx_bit = !last_bit;
            if (cnt == 6'(T_TRAIL - 1)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (hs_win) begin
         data_p = tx_bit;
         data_n = !tx_bit;
      end
   end

   csi2_crc16 u_crc (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == IDLE),
      .enable (state == PAYLOAD),
      .bit_in (tx_bit),
      .crc    (crc)
   );

endmodule

// File: tb/tb_csi2_lane_tx.sv
// Directed bench for csi2_lane_tx: expected lane bytes are queued per request and
// compared as the lane is deserialised.
module tb_csi2_lane_tx;

   localparam int T_LPX   = 2;
   localparam int T_PREP  = 2;
   localparam int T_ZERO  = 8;
   localparam int T_TRAIL = 4;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        pkt_valid = 1'b0;
   logic [1:0]  pkt_vc    = '0;
   logic [5:0]  pkt_dt    = '0;
   logic [15:0] pkt_wc    = '0;
   logic [7:0]  pl_data   = '0;
   logic        pl_valid  = 1'b0;
   logic        pkt_ready, pl_ready, data_p, data_n, clk_p, clk_n, busy, underrun;

   int errors = 0;
   int checks = 0;
   logic [7:0] expQ[$];
   logic [7:0] plQ[$];
   logic [7:0] srcBytes[$];
   int fetchIdx      = 0;
   int underrunAt    = -1;
   int plReadyCount  = 0;
   int underrunCount = 0;

   always #5 clk = ~clk;

   csi2_lane_tx dut (
      .clk       (clk),
      .reset     (reset),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .pkt_vc    (pkt_vc),
      .pkt_dt    (pkt_dt),
      .pkt_wc    (pkt_wc),
      .pl_data   (pl_data),
      .pl_valid  (pl_valid),
      .pl_ready  (pl_ready),
      .data_p    (data_p),
      .data_n    (data_n),
      .clk_p     (clk_p),
      .clk_n     (clk_n),
      .busy      (busy),
      .underrun  (underrun)
   );

   // Payload source: answers each fetch just after the edge that raised pl_ready.
   initial forever begin
      @(posedge clk);
      #1;
      if (pl_ready === 1'b1) begin
         if (fetchIdx == underrunAt || plQ.size() == 0) begin
            pl_valid = 1'b0;
            pl_data  = 8'h00;
         end else begin
            pl_valid = 1'b1;
            pl_data  = plQ.pop_front();
         end
         fetchIdx++;
      end else begin
         pl_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (pl_ready === 1'b1) plReadyCount++;
      if (underrun === 1'b1) underrunCount++;
   end

   function automatic logic [7:0] eccModel(input logic [23:0] d);
      logic [7:0] col [24];
      logic [7:0] e;
      col = '{8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
              8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
              8'h31, 8'h32, 8'h34, 8'h38, 8'h1F, 8'h2F, 8'h37, 8'h3B};
      e = 8'h00;
      for (int i = 0; i < 24; i++) if (d[i]) e = e ^ col[i];
      return e;
   endfunction

   function automatic logic [15:0] crcModel(input logic [15:0] crcIn, input logic [7:0] b);
      logic [15:0] c;
      c = crcIn ^ {8'h00, b};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one request, queues its expected lane bytes, returns at the first LPX cycle.
   task automatic applyStimulus(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                                input bit hold, input int stallAt, output int waited);
      logic [7:0]  id;
      logic [7:0]  b;
      logic [15:0] crc;
      id = {vc, dt};
      pkt_vc = vc;
      pkt_dt = dt;
      pkt_wc = wc;
      pkt_valid = 1'b1;
      plQ.delete();
      expQ.delete();
      fetchIdx      = 0;
      underrunAt    = stallAt;
      plReadyCount  = 0;
      underrunCount = 0;
      expQ.push_back(8'hB8);
      expQ.push_back(id);
      expQ.push_back(wc[7:0]);
      expQ.push_back(wc[15:8]);
      expQ.push_back(eccModel({wc, id}));
      if (dt >= 6'h10) begin
         crc = 16'hFFFF;
         for (int i = 0; i < int'(wc); i++) begin
            if (i == stallAt) b = 8'h00;
            else begin
               b = srcBytes[i];
               plQ.push_back(b);
            end
            expQ.push_back(b);
            crc = crcModel(crc, b);
         end
         expQ.push_back(crc[7:0]);
         expQ.push_back(crc[15:8]);
      end
      waited = 0;
      while (pkt_ready !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("accept_within_bound", 32'(waited < 300), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (!hold) pkt_valid = 1'b0;
      checkOutput("pkt_ready_drops", 32'(pkt_ready), 32'd0);
      checkOutput("busy_after_accept", 32'(busy), 32'd1);
   endtask

   // Walks the lane from the first LPX cycle to the first IDLE cycle after the trail.
   task automatic checkPacket(input int nPlReady, input int nUnderrun);
      int entryBad, hsBad, clkBad, idx;
      logic prevClk, lastBit;
      logic [1:0] expLane;
      logic [7:0] got, exp;
      entryBad = 0;
      hsBad    = 0;
      clkBad   = 0;
      idx      = 0;
      prevClk  = 1'b0;
      got      = '0;
      for (int i = 0; i < T_LPX + T_PREP + T_ZERO; i++) begin
         if (i > 0) @(negedge clk);
         if (i < T_LPX) expLane = 2'b01;
         else if (i < T_LPX + T_PREP) expLane = 2'b00;
         else expLane = 2'b01;
         if ({data_p, data_n} !== expLane) entryBad++;
         if (i < T_LPX + T_PREP) begin
            if ({clk_p, clk_n} !== 2'b01) clkBad++;
         end else if (clk_n !== ~clk_p || (i > T_LPX + T_PREP && clk_p === prevClk)) clkBad++;
         prevClk = clk_p;
      end
      checkOutput("lp_entry_and_hs_zero", 32'(entryBad), 32'd0);
      while (expQ.size() > 0) begin
         exp = expQ.pop_front();
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got[k] = data_p;
            if (data_n !== ~data_p) hsBad++;
            if (clk_n !== ~clk_p || clk_p === prevClk) clkBad++;
            prevClk = clk_p;
         end
         checkOutput($sformatf("stream_byte%0d", idx), 32'(got), 32'(exp));
         idx++;
      end
      lastBit = got[7];
      for (int i = 0; i < T_TRAIL; i++) begin
         @(negedge clk);
         if ({data_p, data_n} !== {~lastBit, lastBit}) hsBad++;
         if (clk_n !== ~clk_p || clk_p === prevClk) clkBad++;
         prevClk = clk_p;
      end
      checkOutput("hs_differential_and_trail", 32'(hsBad), 32'd0);
      @(negedge clk);
      checkOutput("lp11_after_trail", 32'({data_p, data_n, clk_p, clk_n}), 32'b1101);
      checkOutput("busy_low_after_trail", 32'(busy), 32'd0);
      checkOutput("pkt_ready_in_idle", 32'(pkt_ready), 32'd1);
      checkOutput("hs_clock_lane", 32'(clkBad), 32'd0);
      checkOutput("pl_ready_pulses", 32'(plReadyCount), 32'(nPlReady));
      checkOutput("underrun_pulses", 32'(underrunCount), 32'(nUnderrun));
   endtask

   initial begin
      int waited;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_pkt_ready", 32'(pkt_ready), 32'd0);
      checkOutput("reset_lanes", 32'({data_p, data_n, clk_p, clk_n}), 32'b1101);
      checkOutput("reset_flags", 32'({busy, pl_ready, underrun}), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("idle_pkt_ready", 32'(pkt_ready), 32'd1);
      @(negedge clk);

      $display("[TB] FS short packet");
      srcBytes.delete();
      applyStimulus(2'd0, 6'h00, 16'h0001, 1'b0, -1, waited);
      checkPacket(0, 0);

      $display("[TB] RAW8 long packet, wc=4");
      srcBytes = {8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(2'd0, 6'h2A, 16'd4, 1'b0, -1, waited);
      checkPacket(4, 0);

      $display("[TB] long packet, wc=0");
      applyStimulus(2'd1, 6'h2A, 16'd0, 1'b0, -1, waited);
      checkPacket(0, 0);

      $display("[TB] underrun on third fetch");
      srcBytes = {8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(2'd0, 6'h2A, 16'd4, 1'b0, 2, waited);
      checkPacket(4, 1);

      $display("[TB] reset during payload");
      srcBytes = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      applyStimulus(2'd3, 6'h2A, 16'd8, 1'b0, -1, waited);
      waited = 0;
      while (plReadyCount < 3 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("reached_payload", 32'(plReadyCount >= 3), 32'd1);
      checkOutput("busy_in_payload", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("pkt_ready_held_in_reset", 32'(pkt_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("abort_lp11", 32'({data_p, data_n, clk_p, clk_n}), 32'b1101);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_pkt_ready", 32'(pkt_ready), 32'd1);
      @(negedge clk);
      srcBytes = {8'hA5, 8'h3C, 8'hFF};
      applyStimulus(2'd2, 6'h2B, 16'd3, 1'b0, -1, waited);
      checkPacket(3, 0);

      $display("[TB] back-to-back requests");
      applyStimulus(2'd1, 6'h02, 16'h0005, 1'b1, -1, waited);
      checkPacket(0, 0);
      applyStimulus(2'd1, 6'h03, 16'h0005, 1'b0, -1, waited);
      checkOutput("b2b_accept_first_idle", 32'(waited), 32'd0);
      checkPacket(0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
